// File: rtl/iis_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iis_pkg
// Description : Shared definitions for the I2S receive controller: one-hot
//               FSM state encoding, default sample width and the lower
//               clamps applied to the bclk divider and the slot length.
// Revision    : 1.0 - initial release
// ============================================================================
package iis_pkg;

  // Default bits captured per channel.
  localparam int DATA_BIT_DEF = 24;

  // Smallest usable bclk half-period in clk cycles.
  localparam int HALF_DIV_MIN = 2;

  // A slot must hold the one-bit I2S delay plus the full sample.
  localparam int SLOT_OFFSET = 1;

  typedef enum logic [6:0] {
    ST_IDLE   = 7'b0000001,
    ST_SKIP_L = 7'b0000010,
    ST_READ_L = 7'b0000100,
    ST_WAIT_R = 7'b0001000,
    ST_SKIP_R = 7'b0010000,
    ST_READ_R = 7'b0100000,
    ST_WAIT_L = 7'b1000000
  } state_t;

endpackage
`default_nettype wire

// File: rtl/iis_pair_fifo.sv
`default_nettype none
// ============================================================================
// Module      : iis_pair_fifo
// Description : Two-entry FIFO holding stereo pairs. A push into a full FIFO
//               that is not relieved by a same-cycle pop is discarded and
//               flagged on drop_o.
// Ports       : clk_100m, rst_n     - clock, async active-low reset
//               push_i, wdata_i     - write request and pair data
//               pop_i               - read request (ignored when empty)
//               rdata_o             - pair at FIFO head
//               full_o, empty_o     - occupancy flags
//               drop_o              - push rejected this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module iis_pair_fifo #(
  parameter int WIDTH = 48
) (
  input  logic             clk_100m,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  logic w_pop;
  logic w_push;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign w_pop   = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push  = push_i && (!full_o || w_pop);
  assign drop_o  = push_i && full_o && !w_pop;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/iis_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : iis_rx_ctrl
// Description : Master-mode I2S receive controller. Generates bclk/lrclk,
//               captures 24-bit left/right samples MSB first with the I2S
//               one-bit delay, and hands stereo pairs to the consumer through
//               a 2-entry valid/ready buffer with sticky overflow reporting.
// Options     : IIS_RX_FRAME_CNT_EN - adds frame_cnt[15:0], counting every
//               completed frame (pushed or dropped), wrapping at 0xFFFF.
// Ports       : clk_100m, rst_n           - clock, async active-low reset
//               en                        - run request (stops on frame end)
//               cfg_half_div, cfg_slot_len- divider / slot config, latched
//                                           when leaving IDLE
//               sdata_i                   - serial data from codec
//               bclk, lrclk               - generated bit / word clocks
//               smp_valid, smp_ready      - pair handshake
//               smp_l, smp_r              - pair at buffer head
//               overflow, ovf_clr         - sticky drop flag and its clear
//               busy                      - FSM not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module iis_rx_ctrl
  import iis_pkg::*;
#(
  parameter int DATA_BIT = DATA_BIT_DEF,
  parameter int DIV_W    = 8,
  parameter int SLOT_W   = 6
) (
  input  logic                clk_100m,
  input  logic                rst_n,
  input  logic                en,
  input  logic [DIV_W-1:0]    cfg_half_div,
  input  logic [SLOT_W-1:0]   cfg_slot_len,
  input  logic                sdata_i,
  output logic                bclk,
  output logic                lrclk,
  output logic                smp_valid,
  input  logic                smp_ready,
  output logic [DATA_BIT-1:0] smp_l,
  output logic [DATA_BIT-1:0] smp_r,
  output logic                overflow,
  input  logic                ovf_clr,
`ifdef IIS_RX_FRAME_CNT_EN
  output logic [15:0]         frame_cnt,
`endif
  output logic                busy
);

  localparam int RD_W = (DATA_BIT > 2) ? $clog2(DATA_BIT) : 1;

  state_t              state_q;
  logic [DIV_W-1:0]    div_q;
  logic [SLOT_W-1:0]   bit_q;
  logic [RD_W-1:0]     rd_q;
  logic                bclk_q;
  logic                lrclk_q;
  logic [DIV_W-1:0]    half_div_q;
  logic [SLOT_W-1:0]   slot_len_q;
  logic [DATA_BIT-1:0] l_q;
  logic [DATA_BIT-1:0] r_q;
  logic                push_q;
  logic                overflow_q;

  logic [DIV_W-1:0]    half_div_d;
  logic [SLOT_W-1:0]   slot_len_d;

  logic w_div_tc;
  logic w_rise;
  logic w_fall;
  logic w_slot_wrap;
  logic w_last_bit;

  logic [2*DATA_BIT-1:0] w_fifo_rdata;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_fifo_drop;
  logic                  w_pop;

  // Clamp configuration to the smallest workable values.
  always_comb begin
    half_div_d = cfg_half_div;
    if (cfg_half_div < DIV_W'(HALF_DIV_MIN)) begin
      half_div_d = DIV_W'(HALF_DIV_MIN);
    end
    slot_len_d = cfg_slot_len;
    if (cfg_slot_len < SLOT_W'(DATA_BIT + SLOT_OFFSET)) begin
      slot_len_d = SLOT_W'(DATA_BIT + SLOT_OFFSET);
    end
  end

  assign w_div_tc    = (div_q == half_div_q - DIV_W'(1));
  // bclk toggles at the terminal count; its current level tells rise from fall.
  assign w_rise      = w_div_tc && !bclk_q;
  assign w_fall      = w_div_tc && bclk_q;
  assign w_slot_wrap = w_fall && (bit_q == slot_len_q - SLOT_W'(1));
  assign w_last_bit  = (rd_q == RD_W'(DATA_BIT - 1));

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      rd_q       <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      half_div_q <= DIV_W'(HALF_DIV_MIN);
      slot_len_q <= SLOT_W'(DATA_BIT + SLOT_OFFSET);
      l_q        <= '0;
      r_q        <= '0;
      push_q     <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        div_q   <= '0;
        bit_q   <= '0;
        rd_q    <= '0;
        bclk_q  <= 1'b0;
        lrclk_q <= 1'b0;
        if (en) begin
          half_div_q <= half_div_d;
          slot_len_q <= slot_len_d;
          state_q    <= ST_SKIP_L;
        end
      end else begin
        // Clock generation runs freely in every active state.
        if (w_div_tc) begin
          div_q  <= '0;
          bclk_q <= ~bclk_q;
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
        if (w_fall) begin
          if (w_slot_wrap) begin
            bit_q   <= '0;
            lrclk_q <= ~lrclk_q;
          end else begin
            bit_q <= bit_q + SLOT_W'(1);
          end
        end

        case (state_q)
          ST_SKIP_L: begin
            if (w_rise) begin
              rd_q    <= '0;
              state_q <= ST_READ_L;
            end
          end
          ST_READ_L: begin
            if (w_rise) begin
              l_q  <= {l_q[DATA_BIT-2:0], sdata_i};
              rd_q <= rd_q + RD_W'(1);
              if (w_last_bit) begin
                state_q <= ST_WAIT_R;
              end
            end
          end
          ST_WAIT_R: begin
            if (w_slot_wrap && !lrclk_q) begin
              state_q <= ST_SKIP_R;
            end
          end
          ST_SKIP_R: begin
            if (w_rise) begin
              rd_q    <= '0;
              state_q <= ST_READ_R;
            end
          end
          ST_READ_R: begin
            if (w_rise) begin
              r_q  <= {r_q[DATA_BIT-2:0], sdata_i};
              rd_q <= rd_q + RD_W'(1);
              if (w_last_bit) begin
                push_q  <= 1'b1;
                state_q <= ST_WAIT_L;
              end
            end
          end
          ST_WAIT_L: begin
            // The left boundary is the only place a stop takes effect; the
            // clock registers land on 0/0 here by themselves.
            if (w_slot_wrap && lrclk_q) begin
              state_q <= en ? ST_SKIP_L : ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign w_pop = !w_fifo_empty && smp_ready;

  iis_pair_fifo #(
    .WIDTH (2 * DATA_BIT)
  ) u_fifo (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .push_i   (push_q),
    .wdata_i  ({l_q, r_q}),
    .pop_i    (w_pop),
    .rdata_o  (w_fifo_rdata),
    .full_o   (w_fifo_full),
    .empty_o  (w_fifo_empty),
    .drop_o   (w_fifo_drop)
  );

  // Sticky overflow; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (w_fifo_drop && w_fifo_full) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

`ifdef IIS_RX_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // One count per completed frame, whether or not the buffer accepted it.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 16'd0;
    end else if (push_q) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  // Frame counter not built.
`endif

  assign bclk      = bclk_q;
  assign lrclk     = lrclk_q;
  assign busy      = (state_q != ST_IDLE);
  assign smp_valid = !w_fifo_empty;
  assign smp_l     = w_fifo_rdata[2*DATA_BIT-1:DATA_BIT];
  assign smp_r     = w_fifo_rdata[DATA_BIT-1:0];
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_iis_rx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_iis_rx_ctrl
// Description : Self-checking bench for iis_rx_ctrl. A codec model drives
//               sdata_i from the generated clocks and records each frame it
//               starts as an expected pair; a monitor compares delivered pairs
//               against that queue. Scenario tasks add direct checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iis_rx_ctrl;

  logic        clk_100m = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  cfg_half_div;
  logic [5:0]  cfg_slot_len;
  logic        sdata_i;
  logic        bclk;
  logic        lrclk;
  logic        smp_valid;
  logic        smp_ready;
  logic [23:0] smp_l;
  logic [23:0] smp_r;
  logic        overflow;
  logic        ovf_clr;
  logic        busy;
`ifdef IIS_RX_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [47:0] codec_q [$];
  logic [47:0] exp_q   [$];
  logic [47:0] got_q   [$];
  logic [47:0] sb_exp;
  int          frames_started = 0;

  always #5 clk_100m = ~clk_100m;

  iis_rx_ctrl dut (
    .clk_100m     (clk_100m),
    .rst_n        (rst_n),
    .en           (en),
    .cfg_half_div (cfg_half_div),
    .cfg_slot_len (cfg_slot_len),
    .sdata_i      (sdata_i),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .smp_valid    (smp_valid),
    .smp_ready    (smp_ready),
    .smp_l        (smp_l),
    .smp_r        (smp_r),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr),
`ifdef IIS_RX_FRAME_CNT_EN
    .frame_cnt    (frame_cnt),
`endif
    .busy         (busy)
  );

  // Codec model: one-bit delay after each lrclk change, MSB first, data
  // changes just after bclk falls.
  initial begin : codec
    logic        pb, plr, pbusy;
    int          cnt;
    logic [23:0] cur_w, cur_r_w;
    logic [47:0] fr;
    pb = 1'b0; plr = 1'b0; pbusy = 1'b0; cnt = 0;
    cur_w = '0; cur_r_w = '0; sdata_i = 1'b0;
    forever begin
      @(posedge clk_100m); #1;
      if (busy !== 1'b1) begin
        cnt = 0;
        sdata_i = 1'b0;
      end else if (!pbusy || (lrclk == 1'b0 && plr == 1'b1)) begin
        fr = (codec_q.size() > 0) ? codec_q.pop_front() : 48'h0;
        exp_q.push_back(fr);
        frames_started++;
        cur_w = fr[47:24];
        cur_r_w = fr[23:0];
        cnt = 0;
        sdata_i = 1'b0;
      end else if (lrclk == 1'b1 && plr == 1'b0) begin
        cur_w = cur_r_w;
        cnt = 0;
        sdata_i = 1'b0;
      end else if (pb && !bclk) begin
        cnt++;
        if (cnt >= 1 && cnt <= 24) sdata_i = cur_w[24-cnt];
        else sdata_i = 1'b0;
      end
      pb = bclk; plr = lrclk; pbusy = busy;
    end
  end

  // Scoreboard: every transfer must match the oldest frame the codec sent.
  always @(negedge clk_100m) begin
    if (rst_n === 1'b1 && smp_valid === 1'b1 && smp_ready === 1'b1) begin
      n_assert++;
      got_q.push_back({smp_l, smp_r});
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_pair: got l=%h r=%h, required no transfer", smp_l, smp_r);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({smp_l, smp_r} !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_pair: got l=%h r=%h, required l=%h r=%h",
                   smp_l, smp_r, sb_exp[47:24], sb_exp[23:0]);
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_100m);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    for (int t = 0; t < limit && busy !== 1'b0; t++) begin
      @(posedge clk_100m); #1;
    end
  endtask

  // Clock cycles between two successive rises of bclk (sel=0) or lrclk (sel=1);
  // -1 if no rise shows up in time.
  task automatic measure_period(input bit sel, output int per);
    logic prev, cur;
    bit   found;
    per = -1;
    found = 1'b0;
    prev = sel ? lrclk : bclk;
    for (int t = 0; t < 10000 && !found; t++) begin
      @(posedge clk_100m); #1;
      cur = sel ? lrclk : bclk;
      if (!prev && cur) found = 1'b1;
      prev = cur;
    end
    if (!found) return;
    found = 1'b0;
    for (int t = 1; t <= 10000 && !found; t++) begin
      @(posedge clk_100m); #1;
      cur = sel ? lrclk : bclk;
      if (!prev && cur) begin
        found = 1'b1;
        per = t;
      end
      prev = cur;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; ovf_clr = 1'b0; smp_ready = 1'b1;
    cfg_half_div = 8'd16; cfg_slot_len = 6'd32;
    wait_clks(3);
    n_assert++;
    if ({bclk, lrclk, smp_valid, overflow, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got bclk,lrclk,valid,ovf,busy=%b, required 00000",
               {bclk, lrclk, smp_valid, overflow, busy});
    end
    n_assert++;
    if ({smp_l, smp_r} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, required 0", {smp_l, smp_r});
    end
    rst_n = 1'b1;
    wait_clks(20);
    n_assert++;
    if ({bclk, lrclk, smp_valid, overflow, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_idle_en0: got %b, required 00000",
               {bclk, lrclk, smp_valid, overflow, busy});
    end
  endtask

  task automatic test_basic();
    int          per;
    logic [47:0] g;
    cfg_half_div = 8'd16; cfg_slot_len = 6'd32; smp_ready = 1'b1;
    codec_q.delete(); got_q.delete();
    codec_q.push_back({24'hA5A5A5, 24'h5A5A5A});
    en = 1'b1;
    measure_period(1'b0, per);
    n_assert++;
    if (per !== 32) begin
      n_fail++;
      $display("FAIL basic_bclk_period: got %0d clk, required 32", per);
    end
    measure_period(1'b1, per);
    n_assert++;
    if (per !== 2048) begin
      n_fail++;
      $display("FAIL basic_lrclk_period: got %0d clk, required 2048", per);
    end
    en = 1'b0;
    wait_idle(6000);
    n_assert++;
    if ({busy, bclk, lrclk} !== 3'b000) begin
      n_fail++;
      $display("FAIL basic_stop: got busy,bclk,lrclk=%b, required 000", {busy, bclk, lrclk});
    end
    wait_clks(5);
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_drain: got %0d pairs outstanding, required 0", exp_q.size());
    end
    g = (got_q.size() > 0) ? got_q[0] : 48'h0;
    n_assert++;
    if (g !== {24'hA5A5A5, 24'h5A5A5A}) begin
      n_fail++;
      $display("FAIL basic_first_pair: got %h, required a5a5a55a5a5a", g);
    end
  endtask

  task automatic test_overflow();
    int          base;
    logic [47:0] g0, g1;
    cfg_half_div = 8'd4; cfg_slot_len = 6'd32; smp_ready = 1'b0;
    codec_q.delete(); got_q.delete(); exp_q.delete();
    codec_q.push_back({24'h000001, 24'h000010});
    codec_q.push_back({24'h000002, 24'h000020});
    codec_q.push_back({24'h000003, 24'h000030});
    base = frames_started;
    en = 1'b1;
    for (int t = 0; t < 5000 && frames_started < base + 3; t++) begin
      @(posedge clk_100m); #1;
    end
    en = 1'b0;
    wait_idle(2000);
    wait_clks(2);
    n_assert++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got overflow=%b, required 1", overflow);
    end
    n_assert++;
    if (exp_q.size() != 3) begin
      n_fail++;
      $display("FAIL ovf_frames_sent: got %0d frames, required 3", exp_q.size());
    end
    // The third frame met a full buffer and was discarded.
    if (exp_q.size() == 3) exp_q.delete(2);
    smp_ready = 1'b1;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
      @(posedge clk_100m); #1;
    end
    wait_clks(3);
    n_assert++;
    if (smp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_valid_fall: got smp_valid=%b, required 0", smp_valid);
    end
    g0 = (got_q.size() > 0) ? got_q[0] : 48'h0;
    g1 = (got_q.size() > 1) ? got_q[1] : 48'h0;
    n_assert++;
    if (got_q.size() != 2 || g0 !== {24'h1, 24'h10} || g1 !== {24'h2, 24'h20}) begin
      n_fail++;
      $display("FAIL ovf_order: got n=%0d %h %h, required n=2 000001000010 000002000020",
               got_q.size(), g0, g1);
    end
    ovf_clr = 1'b1;
    wait_clks(1);
    ovf_clr = 1'b0;
    n_assert++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: got overflow=%b, required 0", overflow);
    end
  endtask

  task automatic test_stop();
    logic [47:0] g;
    cfg_half_div = 8'd16; cfg_slot_len = 6'd32; smp_ready = 1'b1;
    codec_q.delete(); got_q.delete(); exp_q.delete();
    codec_q.push_back({24'h123456, 24'h654321});
    en = 1'b1;
    // 160 clk after start is a few bits into the left sample.
    wait_clks(160);
    en = 1'b0;
    wait_idle(6000);
    n_assert++;
    if ({busy, bclk, lrclk} !== 3'b000) begin
      n_fail++;
      $display("FAIL stop_idle: got busy,bclk,lrclk=%b, required 000", {busy, bclk, lrclk});
    end
    g = (got_q.size() > 0) ? got_q[0] : 48'h0;
    n_assert++;
    if (got_q.size() != 1 || g !== {24'h123456, 24'h654321}) begin
      n_fail++;
      $display("FAIL stop_frame: got n=%0d %h, required n=1 123456654321", got_q.size(), g);
    end
    wait_clks(3000);
    n_assert++;
    if (got_q.size() != 1 || smp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_quiet: got n=%0d valid=%b busy=%b, required n=1 valid=0 busy=0",
               got_q.size(), smp_valid, busy);
    end
  endtask

  task automatic test_clamp();
    int          per;
    logic [47:0] g0, g1;
    cfg_half_div = 8'd1; cfg_slot_len = 6'd20; smp_ready = 1'b1;
    codec_q.delete(); got_q.delete(); exp_q.delete();
    codec_q.push_back({24'hC0FFEE, 24'h13579B});
    codec_q.push_back({24'h800001, 24'h7FFFFE});
    en = 1'b1;
    measure_period(1'b0, per);
    n_assert++;
    if (per !== 4) begin
      n_fail++;
      $display("FAIL clamp_bclk_period: got %0d clk, required 4", per);
    end
    measure_period(1'b1, per);
    n_assert++;
    if (per !== 200) begin
      n_fail++;
      $display("FAIL clamp_lrclk_period: got %0d clk, required 200", per);
    end
    en = 1'b0;
    wait_idle(1000);
    wait_clks(5);
    g0 = (got_q.size() > 0) ? got_q[0] : 48'h0;
    g1 = (got_q.size() > 1) ? got_q[1] : 48'h0;
    n_assert++;
    if (got_q.size() != 2 || g0 !== {24'hC0FFEE, 24'h13579B} || g1 !== {24'h800001, 24'h7FFFFE}) begin
      n_fail++;
      $display("FAIL clamp_capture: got n=%0d %h %h, required n=2 c0ffee13579b 8000017ffffe",
               got_q.size(), g0, g1);
    end
  endtask

  task automatic test_reset_mid();
    logic [47:0] g;
    cfg_half_div = 8'd4; cfg_slot_len = 6'd32; smp_ready = 1'b1;
    codec_q.delete(); got_q.delete(); exp_q.delete();
    codec_q.push_back({24'h111111, 24'h222222});
    codec_q.push_back({24'h333333, 24'h444444});
    en = 1'b1;
    wait_clks(2);
    for (int t = 0; t < 2000 && lrclk !== 1'b1; t++) begin
      @(posedge clk_100m); #1;
    end
    // About ten bits into the right sample.
    wait_clks(80);
    rst_n = 1'b0;
    exp_q.delete();
    wait_clks(3);
    n_assert++;
    if ({smp_valid, busy, bclk, lrclk} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_clear: got valid,busy,bclk,lrclk=%b, required 0000",
               {smp_valid, busy, bclk, lrclk});
    end
    rst_n = 1'b1;
    for (int t = 0; t < 2000 && got_q.size() == 0; t++) begin
      @(posedge clk_100m); #1;
    end
    en = 1'b0;
    wait_idle(2000);
    wait_clks(5);
    g = (got_q.size() > 0) ? got_q[0] : 48'h0;
    n_assert++;
    if (got_q.size() != 1 || g !== {24'h333333, 24'h444444}) begin
      n_fail++;
      $display("FAIL rstmid_restart: got n=%0d %h, required n=1 333333444444", got_q.size(), g);
    end
    n_assert++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_end: got busy=%b pending=%0d, required busy=0 pending=0",
               busy, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_stop();
    test_clamp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
